// File: rtl/io_input_ctrl_if.sv
// CPU-side request/acknowledge bus of the input-port controller.
// The master drives requests; the slave (controller) returns data and acks.
interface io_input_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      addr;
  logic             rd_req;
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ack;
  logic             wr_ack;

  modport master (
    output addr, rd_req, wr_req, wr_data,
    input  rd_data, rd_ack, wr_ack
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_data,
    output rd_data, rd_ack, wr_ack
  );
endinterface

// File: rtl/io_input_ctrl.sv
// Memory-mapped controller for two asynchronous 32-bit input ports: synchronise,
// sample on a periodic tick, flag new data, raise a maskable irq, serve CPU accesses.
//
// state     | meaning
// ST_IDLE   | waiting for rd_req/wr_req; an access is decoded on the next edge
// ST_RESP   | ack is high for this cycle; requests are ignored
module io_input_ctrl #(
  parameter int WIDTH      = 32,
  parameter int SAMPLE_DIV = 4
) (
  input  logic             io_clk,
  input  logic             reset,
  io_input_ctrl_if.slave   bus,
  input  logic [WIDTH-1:0] in_port0_i,
  input  logic [WIDTH-1:0] in_port1_i,
  output logic             irq_o
);

  localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [5:0] IDX_HOLD0  = 6'b110000;
  localparam logic [5:0] IDX_HOLD1  = 6'b110001;
  localparam logic [5:0] IDX_STATUS = 6'b110010;
  localparam logic [5:0] IDX_MASK   = 6'b110011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] sync0_q1, sync0_q2;
  logic [WIDTH-1:0] sync1_q1, sync1_q2;
  logic [WIDTH-1:0] hold0_q, hold1_q;
  logic [1:0]       new_flag_q, new_flag_d;
  logic [1:0]       mask_q, mask_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_ack_q, rd_ack_d;
  logic             wr_ack_q, wr_ack_d;
  logic             irq_q, irq_d;

  logic             tick;
  logic [1:0]       port_changed;
  logic [1:0]       rd_clr;
  logic [5:0]       idx;
  logic [WIDTH-1:0] rd_val;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr[31:8], bus.addr[1:0], bus.wr_data[WIDTH-1:2]};

  assign idx  = bus.addr[7:2];
  assign tick = (sample_cnt_q == CNT_LAST);

  assign port_changed[0] = (sync0_q2 != hold0_q);
  assign port_changed[1] = (sync1_q2 != hold1_q);

  always_comb begin
    sample_cnt_d = sample_cnt_q + CNT_ONE;
    if (tick) begin
      sample_cnt_d = '0;
    end
  end

  // Register decode always sees pre-edge values, so a read on a tick edge
  // returns the hold value from before that tick.
  always_comb begin
    rd_val = '0;
    case (idx)
      IDX_HOLD0:  rd_val = hold0_q;
      IDX_HOLD1:  rd_val = hold1_q;
      IDX_STATUS: rd_val = {{(WIDTH-2){1'b0}}, new_flag_q};
      IDX_MASK:   rd_val = {{(WIDTH-2){1'b0}}, mask_q};
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    mask_d    = mask_q;
    rd_clr    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (bus.rd_req) begin
          rd_data_d = rd_val;
          rd_ack_d  = 1'b1;
          state_d   = ST_RESP;
          rd_clr[0] = (idx == IDX_HOLD0);
          rd_clr[1] = (idx == IDX_HOLD1);
        end else if (bus.wr_req) begin
          wr_ack_d = 1'b1;
          state_d  = ST_RESP;
          if (idx == IDX_MASK) begin
            mask_d = bus.wr_data[1:0];
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A tick setting a flag beats a read clearing it on the same edge.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      new_flag_d[p] = new_flag_q[p];
      if (rd_clr[p]) begin
        new_flag_d[p] = 1'b0;
      end
      if (tick && port_changed[p]) begin
        new_flag_d[p] = 1'b1;
      end
    end
  end

  assign irq_d = |(new_flag_q & mask_q);

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      sync0_q1 <= '0;
      sync0_q2 <= '0;
      sync1_q1 <= '0;
      sync1_q2 <= '0;
    end else begin
      sync0_q1 <= in_port0_i;
      sync0_q2 <= sync0_q1;
      sync1_q1 <= in_port1_i;
      sync1_q2 <= sync1_q1;
    end
  end

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      sample_cnt_q <= '0;
      hold0_q      <= '0;
      hold1_q      <= '0;
      new_flag_q   <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      new_flag_q   <= new_flag_d;
      if (tick) begin
        hold0_q <= sync0_q2;
        hold1_q <= sync1_q2;
      end
    end
  end

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_ack  = rd_ack_q;
  assign bus.wr_ack  = wr_ack_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the register map and handshake.
module tb_io_input_ctrl;
  localparam int DIV = 4;

  logic        io_clk = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] in_port0 = '0;
  logic [31:0] in_port1 = '0;
  logic        irq;

  io_input_ctrl_if #(.WIDTH(32)) bus ();

  io_input_ctrl #(.WIDTH(32), .SAMPLE_DIV(DIV)) dut (
    .io_clk     (io_clk),
    .reset      (reset),
    .bus        (bus),
    .in_port0_i (in_port0),
    .in_port1_i (in_port1),
    .irq_o      (irq)
  );

  always #5 io_clk = ~io_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural model state
  logic [31:0] m_pin1[2], m_pin2[2], m_hold[2], m_rd_data;
  logic [1:0]  m_flag, m_mask;
  int          m_cycle;
  logic        m_busy, m_rd_ack, m_wr_ack, m_irq;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pin1[p] = '0; m_pin2[p] = '0; m_hold[p] = '0;
    end
    m_flag = '0; m_mask = '0; m_cycle = 0; m_busy = 0;
    m_rd_ack = 0; m_wr_ack = 0; m_irq = 0; m_rd_data = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[7:0] & 8'hFC)
      8'hC0:   return m_hold[0];
      8'hC4:   return m_hold[1];
      8'hC8:   return {30'b0, m_flag};
      8'hCC:   return {30'b0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  // One rising edge of the model, from the inputs currently on the pins/bus.
  task automatic model_edge();
    logic        tick, do_rd, do_wr;
    logic [1:0]  nflag;
    logic [7:0]  a8;
    tick  = ((m_cycle % DIV) == DIV - 1);
    do_rd = !m_busy && bus.rd_req;
    do_wr = !m_busy && bus.wr_req && !bus.rd_req;
    a8    = bus.addr[7:0] & 8'hFC;
    m_irq = |(m_flag & m_mask);
    nflag = m_flag;
    if (do_rd && a8 == 8'hC0) nflag[0] = 1'b0;
    if (do_rd && a8 == 8'hC4) nflag[1] = 1'b0;
    for (int p = 0; p < 2; p++)
      if (tick && m_pin2[p] != m_hold[p]) nflag[p] = 1'b1;
    if (do_rd) m_rd_data = model_read(bus.addr);
    if (do_wr && a8 == 8'hCC) m_mask = bus.wr_data[1:0];
    if (tick) begin
      m_hold[0] = m_pin2[0];
      m_hold[1] = m_pin2[1];
    end
    m_pin2[0] = m_pin1[0]; m_pin2[1] = m_pin1[1];
    m_pin1[0] = in_port0;  m_pin1[1] = in_port1;
    m_flag   = nflag;
    m_rd_ack = do_rd;
    m_wr_ack = do_wr;
    m_busy   = do_rd || do_wr;
    m_cycle++;
  endtask

  task automatic cyc();
    @(posedge io_clk);
    model_edge();
    #1;
    check("rd_ack", {31'b0, bus.rd_ack}, {31'b0, m_rd_ack});
    check("wr_ack", {31'b0, bus.wr_ack}, {31'b0, m_wr_ack});
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    check("rd_data", bus.rd_data, m_rd_data);
  endtask

  task automatic idle(input int n);
    bus.rd_req = 0; bus.wr_req = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // One access: request for a single edge, then a cycle with requests low.
  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, output logic [31:0] rdata);
    bus.addr = a; bus.rd_req = rd; bus.wr_req = wr; bus.wr_data = wd;
    cyc();
    rdata = bus.rd_data;
    bus.rd_req = 0; bus.wr_req = 0;
    cyc();
  endtask

  logic [31:0] rv;
  int          acks;

  initial begin
    bus.addr = '0; bus.rd_req = 0; bus.wr_req = 0; bus.wr_data = '0;
    model_reset();
    repeat (2) @(posedge io_clk);
    #1;
    check("reset_rd_ack", {31'b0, bus.rd_ack}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 0;

    // Sample latency and status flag
    in_port0 = 32'hA5A5_0001;
    idle(8);
    access(32'hC8, 1, 0, 0, rv);
    check("status_after_sample", rv, 32'h1);
    access(32'hC0, 1, 0, 0, rv);
    check("hold0_sample", rv, 32'hA5A5_0001);
    idle(8);
    access(32'hC8, 1, 0, 0, rv);
    check("status_after_clear", rv, 32'h0);

    // IRQ on port1 only
    access(32'hCC, 0, 1, 32'h2, rv);
    in_port1 = 32'h0000_1234;
    idle(10);
    check("irq_set", {31'b0, irq}, 32'h1);
    access(32'hC4, 1, 0, 0, rv);
    check("hold1_read", rv, 32'h0000_1234);
    idle(1);
    check("irq_clear", {31'b0, irq}, 32'h0);
    in_port0 = 32'h0F0F_0F0F;
    idle(10);
    check("irq_port0_masked", {31'b0, irq}, 32'h0);

    // Read of hold1 on the same edge as a tick carrying a new port1 value
    in_port1 = 32'hBEEF_0000;
    idle(3);
    for (int i = 0; i < 2 * DIV && (m_cycle % DIV) != DIV - 1; i++) cyc();
    check("collision_aligned", m_cycle % DIV, DIV - 1);
    access(32'hC4, 1, 0, 0, rv);
    check("collision_old_hold1", rv, 32'h0000_1234);
    access(32'hC8, 1, 0, 0, rv);
    check("collision_flag1", rv & 32'h2, 32'h2);
    access(32'hC4, 1, 0, 0, rv);
    check("collision_new_hold1", rv, 32'hBEEF_0000);

    // Held read request: one ack per two cycles
    bus.addr = 32'hC8; bus.rd_req = 1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.rd_ack) acks++;
    end
    check("held_rd_acks", acks, 3);
    idle(1);
    access(32'hCC, 1, 1, 32'h1, rv);
    check("rd_wins_data", rv, 32'h2);
    access(32'hCC, 1, 0, 0, rv);
    check("mask_unchanged", rv, 32'h2);
    access(32'hD0, 1, 0, 0, rv);
    check("unmapped_read", rv, 32'h0);

    // Reset in the middle of a response cycle
    bus.addr = 32'hC4; bus.rd_req = 1;
    cyc();
    bus.rd_req = 0;
    #2 reset = 1;
    model_reset();
    #1;
    check("rst_rd_ack", {31'b0, bus.rd_ack}, 32'h0);
    check("rst_wr_ack", {31'b0, bus.wr_ack}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rd_data", bus.rd_data, 32'h0);
    in_port0 = '0; in_port1 = '0;
    @(posedge io_clk);
    #1 reset = 0;
    access(32'hCC, 1, 0, 0, rv);
    check("rst_mask", rv, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) in_port0 = $urandom;
      if ($urandom_range(7) == 0) in_port1 = $urandom;
      case ($urandom_range(5))
        0: bus.addr = 32'hC0;
        1: bus.addr = 32'hC4;
        2: bus.addr = 32'hC8;
        3: bus.addr = 32'hCC;
        4: bus.addr = 32'hD0;
        default: bus.addr = $urandom;
      endcase
      bus.rd_req  = ($urandom_range(2) == 0);
      bus.wr_req  = ($urandom_range(2) == 0);
      bus.wr_data = $urandom;
      cyc();
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
